// File: rtl/noc_ingress_arbiter.sv
// Packet-atomic round-robin arbiter feeding the single NoC ingress link.
// A grant is held from head flit to tail flit; over-long packets are force-released.
module noc_ingress_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int FLIT_W        = 64,
  parameter int MAX_PKT_FLITS = 16,
  localparam int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ*FLIT_W-1:0] req_flit,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [FLIT_W-1:0]         out_flit,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ID_W-1:0]           grant_id,
  output logic                      pkt_err,
  output logic [ID_W-1:0]           err_id
);

  localparam int CNT_W = $clog2(MAX_PKT_FLITS + 1);
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_LOCK = 1'b1;

  logic [0:0]         r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [ID_W-1:0]    r_grant_id;
  logic               r_pkt_err;
  logic [ID_W-1:0]    r_err_id;
  logic [FLIT_W-1:0]  r_out_flit;
  logic               r_out_valid;

  logic               w_rr_found;
  logic [ID_W-1:0]    w_rr_id;
  logic               w_sel_valid;
  logic [ID_W-1:0]    w_sel_id;
  logic [FLIT_W-1:0]  w_sel_flit;
  logic               w_sel_last;
  logic               w_load_en;
  logic               w_accept;
  logic               w_overflow;
  logic [NUM_REQ-1:0] w_req_ready;

  // Round-robin search starting just after the last packet owner.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_id    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!w_rr_found && req_valid[(int'(r_rr_ptr) + k) % NUM_REQ]) begin
        w_rr_found = 1'b1;
        w_rr_id    = ID_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      end else begin
        w_rr_found = w_rr_found;
      end
    end
  end

  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_id    = '0;
    case (r_state)
      S_IDLE: begin
        w_sel_valid = w_rr_found;
        w_sel_id    = w_rr_id;
      end
      S_LOCK: begin
        w_sel_valid = req_valid[r_grant_id];
        w_sel_id    = r_grant_id;
      end
      default: begin
        w_sel_valid = 1'b0;
        w_sel_id    = '0;
      end
    endcase
  end

  always_comb begin
    w_sel_flit = '0;
    w_sel_last = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_sel_id == ID_W'(i)) begin
        w_sel_flit = req_flit[i*FLIT_W +: FLIT_W];
        w_sel_last = req_last[i];
      end else begin
        w_sel_flit = w_sel_flit;
      end
    end
  end

  assign w_load_en  = !r_out_valid || out_ready;
  assign w_accept   = w_load_en && w_sel_valid && !rst;
  assign w_overflow = w_accept && !w_sel_last && (r_cnt == CNT_W'(MAX_PKT_FLITS - 1));

  // Ready is forced low while reset is held so the link goes quiet without a clock.
  always_comb begin
    w_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_req_ready[i] = w_accept && (w_sel_id == ID_W'(i));
    end
  end

  // Arbitration state, packet length count and error reporting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_rr_ptr   <= ID_W'(NUM_REQ - 1);
      r_grant_id <= '0;
      r_pkt_err  <= 1'b0;
      r_err_id   <= '0;
    end else begin
      r_pkt_err <= w_overflow;
      if (w_overflow) begin
        r_err_id <= w_sel_id;
      end
      if (w_accept) begin
        r_grant_id <= w_sel_id;
        if (w_sel_last || w_overflow) begin
          r_state  <= S_IDLE;
          r_rr_ptr <= w_sel_id;
          r_cnt    <= '0;
        end else begin
          r_state  <= S_LOCK;
          r_cnt    <= r_cnt + CNT_W'(1);
        end
      end
    end
  end

  // Single output register; a new flit may replace one leaving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_flit  <= '0;
      r_out_valid <= 1'b0;
    end else if (w_accept) begin
      r_out_flit  <= w_sel_flit;
      r_out_valid <= 1'b1;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign req_ready = w_req_ready;
  assign out_flit  = r_out_flit;
  assign out_valid = r_out_valid;
  assign grant_id  = r_grant_id;
  assign pkt_err   = r_pkt_err;
  assign err_id    = r_err_id;

endmodule
